trace_capture_ctrl: RTL and testbench
=====================================

TRACE_CAPTURE_CTRL -- requirements
Module: trace_capture_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 30, probe width (leds[5:0] + clockCounter[23:0]).
REQ-002 SHALL have parameter AW, default 10, buffer address width; DEPTH = 2^AW.
REQ-003 SHALL have port clk  in  1  single clock for all logic.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port arm  in  1  single-cycle pulse: start a capture.
REQ-006 SHALL have port abort  in  1  single-cycle pulse: cancel a capture.
REQ-007 SHALL have port probe_i  in  WIDTH  sampled signals.
REQ-008 SHALL have port trig_mask / trig_value  in  WIDTH each  trigger compare config.
REQ-009 SHALL have port pre_count / post_count  in  AW each  samples kept before / after the trigger.
REQ-010 SHALL have port wr_en / wr_addr / wr_data  out  1 / AW / WIDTH  external BSRAM write port.
REQ-011 SHALL have port trig_addr / start_addr  out  AW each  trigger sample address / oldest valid sample address.
REQ-012 SHALL have port busy / done  out  1 each  capture in progress / capture complete.
REQ-013 SHALL have port state_o  out  3  current FSM state code.

Function
REQ-014 SHALL implement states IDLE=0, FILL=1, WAIT_TRIG=2, POST=3, DONE=4.
REQ-015 SHALL latch trig_mask, trig_value, pre_count and post_count on the accepted arm; later changes have no effect until the next arm.
REQ-016 SHALL clamp the latched post to DEPTH-1-pre when pre+post+1 > DEPTH.
REQ-017 SHALL accept arm only in IDLE or DONE; arm in FILL/WAIT_TRIG/POST is ignored.
REQ-018 SHALL, on accepted arm: clear done, zero wr_addr and fill counter, go to FILL, or go to WAIT_TRIG when pre=0.
REQ-019 SHALL, in FILL/WAIT_TRIG/POST, register wr_data <= probe_i and assert wr_en one cycle later (1-cycle latency).
REQ-020 SHALL increment wr_addr modulo DEPTH after each write, wrapping DEPTH-1 -> 0.
REQ-021 SHALL, in FILL, count samples and move to WAIT_TRIG on the cycle the pre-th sample is taken.
REQ-022 SHALL define match = ((probe_i ^ trig_value) & trig_mask) == 0 (level, combinational on the current sample).
REQ-023 SHALL ignore match in FILL, so no trigger fires before pre samples are stored.
REQ-024 SHALL, on match in WAIT_TRIG: record trig_addr = address of that sample, start_addr = (trig_addr - pre) mod DEPTH, and go to POST, or to DONE when post=0.
REQ-025 SHALL, in POST, take exactly post further samples, then go to DONE.
REQ-026 SHALL, in DONE, write no more samples (the final pipelined write still completes), assert done=1 and hold trig_addr/start_addr until the next arm.
REQ-027 SHALL, on abort in any non-IDLE state, go to IDLE next cycle with done=0, and suppress wr_en from the following cycle.
REQ-028 SHALL give abort priority when arm and abort are asserted in the same cycle; the state goes to IDLE.
REQ-029 SHALL drive busy=1 exactly in FILL, WAIT_TRIG and POST.
REQ-030 SHALL keep waiting in WAIT_TRIG indefinitely, overwriting the ring; pre-trigger history is the latest pre samples.

Reset
REQ-031 SHALL, while rst_n=0, force state IDLE and set wr_en, wr_addr, wr_data, trig_addr, start_addr, busy, done and latched config to 0, regardless of clk.
REQ-032 SHALL, on reset mid-capture, abandon the capture; first arm after release behaves as REQ-018.

Verification
REQ-033 SHALL cover: pre=4, post=3, mask=0x3F, value=0x05, leds counting 0,1,2,... -> trigger at sample 5, trig_addr=5, start_addr=1, total 9 writes, done=1.
REQ-034 SHALL cover: pre=0, post=0, mask=0 -> trigger on first sample, exactly 1 write at addr 0, trig_addr=0, done next cycle.
REQ-035 SHALL cover: AW=4, pre=2, trigger after 20 samples -> wr_addr wraps 15->0, trig_addr=4, start_addr=2.
REQ-036 SHALL cover: match present during FILL (pre=8, probe matching from cycle 0) -> no trigger until 8 samples taken; trig_addr=8.
REQ-037 SHALL cover: abort in POST, then arm+abort same cycle -> IDLE, done=0, wr_en low; second arm accepted.
REQ-038 SHALL cover: rst_n asserted mid-WAIT_TRIG, asynchronously off a clk edge -> all outputs 0 immediately; pre=1020, post=10 with AW=10 -> post clamped to 3.

Source files
------------

// File: rtl/trace_capture_ctrl.sv
// Trace capture controller: streams probe samples into an external ring
// buffer, keeps a programmable pre-trigger history and post-trigger tail,
// and reports where the trigger sample and the oldest valid sample landed.
module trace_capture_ctrl #(
   parameter int WIDTH = 30,
   parameter int AW    = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             arm,
   input  logic             abort,
   input  logic [WIDTH-1:0] probe_i,
   input  logic [WIDTH-1:0] trig_mask,
   input  logic [WIDTH-1:0] trig_value,
   input  logic [AW-1:0]    pre_count,
   input  logic [AW-1:0]    post_count,
   output logic             wr_en,
   output logic [AW-1:0]    wr_addr,
   output logic [WIDTH-1:0] wr_data,
   output logic [AW-1:0]    trig_addr,
   output logic [AW-1:0]    start_addr,
   output logic             busy,
   output logic             done,
   output logic [2:0]       state_o
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FILL      = 3'd1,
      ST_WAIT_TRIG = 3'd2,
      ST_POST      = 3'd3,
      ST_DONE      = 3'd4
   } state_t;

   localparam logic [AW-1:0] ONE = AW'(1);

   state_t           state_r;
   logic [WIDTH-1:0] mask_r;
   logic [WIDTH-1:0] value_r;
   logic [AW-1:0]    pre_r;
   logic [AW-1:0]    post_r;
   logic [AW-1:0]    ptr_r;
   logic [AW-1:0]    cnt_r;
   logic             match_s;

   // Post length limited so pre + trigger + post never exceeds the ring.
   function automatic logic [AW-1:0] clamp_post(input logic [AW-1:0] pre,
                                                input logic [AW-1:0] post);
      logic [AW+1:0] total;
      total = {2'b00, pre} + {2'b00, post} + {{(AW+1){1'b0}}, 1'b1};
      if (total > {2'b01, {AW{1'b0}}}) begin
         clamp_post = {AW{1'b1}} - pre;
      end else begin
         clamp_post = post;
      end
   endfunction

   assign match_s = (((probe_i ^ value_r) & mask_r) == {WIDTH{1'b0}});
   assign state_o = state_r;

   // Capture FSM with registered write port and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         mask_r     <= {WIDTH{1'b0}};
         value_r    <= {WIDTH{1'b0}};
         pre_r      <= {AW{1'b0}};
         post_r     <= {AW{1'b0}};
         ptr_r      <= {AW{1'b0}};
         cnt_r      <= {AW{1'b0}};
         wr_en      <= 1'b0;
         wr_addr    <= {AW{1'b0}};
         wr_data    <= {WIDTH{1'b0}};
         trig_addr  <= {AW{1'b0}};
         start_addr <= {AW{1'b0}};
         busy       <= 1'b0;
         done       <= 1'b0;
      end else if (abort) begin
         // Abort wins over a simultaneous arm; pending writes are dropped.
         state_r <= ST_IDLE;
         wr_en   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else if (arm && (state_r == ST_IDLE || state_r == ST_DONE)) begin
         mask_r     <= trig_mask;
         value_r    <= trig_value;
         pre_r      <= pre_count;
         post_r     <= clamp_post(pre_count, post_count);
         ptr_r      <= {AW{1'b0}};
         cnt_r      <= {AW{1'b0}};
         wr_en      <= 1'b0;
         wr_addr    <= {AW{1'b0}};
         trig_addr  <= {AW{1'b0}};
         start_addr <= {AW{1'b0}};
         busy       <= 1'b1;
         done       <= 1'b0;
         state_r    <= (pre_count == {AW{1'b0}}) ? ST_WAIT_TRIG : ST_FILL;
      end else begin
         case (state_r)
            ST_FILL, ST_WAIT_TRIG, ST_POST: begin
               // Every capture cycle stores one sample at the ring pointer.
               wr_en   <= 1'b1;
               wr_data <= probe_i;
               wr_addr <= ptr_r;
               ptr_r   <= ptr_r + ONE;
               if (state_r == ST_FILL) begin
                  if (cnt_r == pre_r - ONE) begin
                     cnt_r   <= {AW{1'b0}};
                     state_r <= ST_WAIT_TRIG;
                  end else begin
                     cnt_r <= cnt_r + ONE;
                  end
               end else if (state_r == ST_WAIT_TRIG) begin
                  if (match_s) begin
                     trig_addr  <= ptr_r;
                     start_addr <= ptr_r - pre_r;
                     cnt_r      <= {AW{1'b0}};
                     if (post_r == {AW{1'b0}}) begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                     end else begin
                        state_r <= ST_POST;
                     end
                  end else begin
                     cnt_r <= cnt_r;
                  end
               end else begin
                  if (cnt_r == post_r - ONE) begin
                     state_r <= ST_DONE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     cnt_r <= cnt_r + ONE;
                  end
               end
            end
            ST_IDLE, ST_DONE: begin
               wr_en <= 1'b0;
            end
            default: begin
               state_r <= ST_IDLE;
               wr_en   <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Directed bench for trace_capture_ctrl: a 1024-deep and a 16-deep instance
// share stimulus; each scenario task checks its own expected values.
module tb_trace_capture_ctrl;

   logic        clk;
   logic        rst_n;
   logic        arm;
   logic        abort;
   logic [29:0] probe;
   logic [29:0] mask;
   logic [29:0] value;
   logic [9:0]  pre;
   logic [9:0]  post;

   logic        wr_en, busy, done;
   logic [9:0]  wr_addr, trig_addr, start_addr;
   logic [29:0] wr_data;
   logic [2:0]  state_o;

   logic        s_wr_en, s_busy, s_done;
   logic [3:0]  s_wr_addr, s_trig_addr, s_start_addr;
   logic [29:0] s_wr_data;
   logic [2:0]  s_state_o;

   int errors = 0;
   int checks = 0;

   int         wr_cnt = 0;
   logic [9:0] last_addr = 10'd0;
   logic [5:0] last_leds = 6'd0;
   int         s_wr_cnt = 0;
   int         s_wraps = 0;
   logic [3:0] s_prev = 4'd0;
   logic [3:0] s_last_addr = 4'd0;

   trace_capture_ctrl #(.WIDTH(30), .AW(10)) u_dut (
      .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .probe_i(probe),
      .trig_mask(mask), .trig_value(value), .pre_count(pre), .post_count(post),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .trig_addr(trig_addr), .start_addr(start_addr),
      .busy(busy), .done(done), .state_o(state_o));

   trace_capture_ctrl #(.WIDTH(30), .AW(4)) u_small (
      .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .probe_i(probe),
      .trig_mask(mask), .trig_value(value), .pre_count(pre[3:0]), .post_count(post[3:0]),
      .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
      .trig_addr(s_trig_addr), .start_addr(s_start_addr),
      .busy(s_busy), .done(s_done), .state_o(s_state_o));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write-port monitor for both instances, sampled on the falling edge.
   always @(negedge clk) begin
      if (wr_en) begin
         wr_cnt    = wr_cnt + 1;
         last_addr = wr_addr;
         last_leds = wr_data[5:0];
      end
      if (s_wr_en) begin
         if (s_prev == 4'd15 && s_wr_addr == 4'd0) s_wraps = s_wraps + 1;
         s_prev      = s_wr_addr;
         s_last_addr = s_wr_addr;
         s_wr_cnt    = s_wr_cnt + 1;
      end
   end

   function automatic logic [29:0] mk(input int k);
      logic [23:0] cc;
      logic [5:0]  leds;
      cc   = 24'(k * 3);
      leds = 6'(k);
      mk   = {cc, leds};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic do_arm(input logic [9:0] p, input logic [9:0] q,
                         input logic [29:0] m, input logic [29:0] v);
      pre = p; post = q; mask = m; value = v;
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   // Drives leds counting 0,1,2,... one per cycle until done (bounded).
   task automatic run_count(input int limit, input bit use_small);
      int k;
      k = 0;
      probe = mk(0);
      for (int n = 0; n < limit; n++) begin
         tick();
         k = k + 1;
         probe = mk(k);
         if (use_small ? s_done : done) break;
      end
      checks++;
      if ((use_small ? s_done : done) !== 1'b1) begin
         errors++;
         $display("FAIL run_timeout: done not seen within %0d cycles", limit);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; arm = 1'b0; abort = 1'b0; probe = 30'd0;
      mask = 30'd0; value = 30'd0; pre = 10'd0; post = 10'd0;
      tick(); tick();
      checks++;
      if ({wr_en, wr_addr, wr_data, trig_addr, start_addr, busy, done, state_o} !== 66'd0) begin
         errors++;
         $display("FAIL reset_outputs: got state=%0d wr_en=%0d busy=%0d done=%0d, expected all 0",
                  state_o, wr_en, busy, done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++;
      if (state_o !== 3'd0) begin errors++; $display("FAIL idle_after_reset: state=%0d expected 0", state_o); end
   endtask

   task automatic test_basic();
      int base;
      do_abort();
      base = wr_cnt;
      do_arm(10'd4, 10'd3, 30'h3F, 30'h05);
      checks++;
      if (state_o !== 3'd1 || busy !== 1'b1 || done !== 1'b0) begin
         errors++; $display("FAIL basic_arm: state=%0d busy=%0d done=%0d expected 1/1/0", state_o, busy, done);
      end
      run_count(40, 1'b0);
      tick();
      checks++;
      if (wr_cnt - base !== 9) begin errors++; $display("FAIL basic_writes: got %0d expected 9", wr_cnt - base); end
      checks++;
      if (trig_addr !== 10'd5) begin errors++; $display("FAIL basic_trig: got %0d expected 5", trig_addr); end
      checks++;
      if (start_addr !== 10'd1) begin errors++; $display("FAIL basic_start: got %0d expected 1", start_addr); end
      checks++;
      if (last_addr !== 10'd8 || last_leds !== 6'd8) begin
         errors++; $display("FAIL basic_last: addr=%0d leds=%0d expected 8/8", last_addr, last_leds);
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || state_o !== 3'd4 || wr_en !== 1'b0) begin
         errors++; $display("FAIL basic_done: done=%0d busy=%0d state=%0d wr_en=%0d expected 1/0/4/0",
                            done, busy, state_o, wr_en);
      end
   endtask

   task automatic test_pre_post_zero();
      int base;
      do_abort();
      base = wr_cnt;
      do_arm(10'd0, 10'd0, 30'd0, 30'd0);
      checks++;
      if (state_o !== 3'd2 || busy !== 1'b1) begin
         errors++; $display("FAIL zero_arm: state=%0d busy=%0d expected 2/1", state_o, busy);
      end
      probe = mk(7);
      tick();
      checks++;
      if (done !== 1'b1 || wr_en !== 1'b1 || wr_addr !== 10'd0 || wr_data !== mk(7)) begin
         errors++; $display("FAIL zero_write: done=%0d wr_en=%0d addr=%0d data=%h expected 1/1/0/%h",
                            done, wr_en, wr_addr, wr_data, mk(7));
      end
      checks++;
      if (trig_addr !== 10'd0 || start_addr !== 10'd0 || state_o !== 3'd4) begin
         errors++; $display("FAIL zero_trig: trig=%0d start=%0d state=%0d expected 0/0/4", trig_addr, start_addr, state_o);
      end
      tick();
      checks++;
      if (wr_en !== 1'b0 || wr_cnt - base !== 1) begin
         errors++; $display("FAIL zero_count: wr_en=%0d writes=%0d expected 0/1", wr_en, wr_cnt - base);
      end
   endtask

   task automatic test_wrap();
      int sbase;
      int wbase;
      do_abort();
      sbase = s_wr_cnt;
      wbase = s_wraps;
      do_arm(10'd2, 10'd1, 30'h3F, 30'h14);
      run_count(40, 1'b1);
      tick();
      checks++;
      if (s_trig_addr !== 4'd4 || s_start_addr !== 4'd2) begin
         errors++; $display("FAIL wrap_trig: trig=%0d start=%0d expected 4/2", s_trig_addr, s_start_addr);
      end
      checks++;
      if (s_wraps - wbase !== 1 || s_wr_cnt - sbase !== 22 || s_last_addr !== 4'd5) begin
         errors++; $display("FAIL wrap_ring: wraps=%0d writes=%0d last=%0d expected 1/22/5",
                            s_wraps - wbase, s_wr_cnt - sbase, s_last_addr);
      end
      checks++;
      if (trig_addr !== 10'd20 || start_addr !== 10'd18) begin
         errors++; $display("FAIL wrap_wide: trig=%0d start=%0d expected 20/18", trig_addr, start_addr);
      end
   endtask

   task automatic test_match_in_fill();
      int base;
      do_abort();
      base = wr_cnt;
      do_arm(10'd8, 10'd2, 30'h3F, 30'h2A);
      probe = 30'h2A;
      repeat (8) tick();
      checks++;
      if (state_o !== 3'd2 || trig_addr !== 10'd0) begin
         errors++; $display("FAIL fill_hold: state=%0d trig=%0d expected 2/0", state_o, trig_addr);
      end
      tick();
      checks++;
      if (state_o !== 3'd3 || trig_addr !== 10'd8 || start_addr !== 10'd0) begin
         errors++; $display("FAIL fill_trig: state=%0d trig=%0d start=%0d expected 3/8/0", state_o, trig_addr, start_addr);
      end
      tick(); tick();
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL fill_done: done=%0d expected 1", done); end
      tick();
      checks++;
      if (wr_cnt - base !== 11) begin errors++; $display("FAIL fill_writes: got %0d expected 11", wr_cnt - base); end
   endtask

   task automatic test_abort();
      int base;
      do_abort();
      base = wr_cnt;
      do_arm(10'd1, 10'd5, 30'd0, 30'd0);
      probe = mk(0);
      tick(); tick(); tick();
      checks++;
      if (state_o !== 3'd3) begin errors++; $display("FAIL abort_pre: state=%0d expected 3", state_o); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (state_o !== 3'd0 || done !== 1'b0 || busy !== 1'b0 || wr_en !== 1'b0) begin
         errors++; $display("FAIL abort_post: state=%0d done=%0d busy=%0d wr_en=%0d expected 0/0/0/0",
                            state_o, done, busy, wr_en);
      end
      tick();
      checks++;
      if (wr_cnt - base !== 3 || wr_en !== 1'b0) begin
         errors++; $display("FAIL abort_writes: writes=%0d wr_en=%0d expected 3/0", wr_cnt - base, wr_en);
      end
      arm = 1'b1; abort = 1'b1;
      tick();
      arm = 1'b0; abort = 1'b0;
      checks++;
      if (state_o !== 3'd0 || busy !== 1'b0 || wr_en !== 1'b0) begin
         errors++; $display("FAIL arm_abort: state=%0d busy=%0d wr_en=%0d expected 0/0/0", state_o, busy, wr_en);
      end
      do_arm(10'd1, 10'd5, 30'd0, 30'd0);
      checks++;
      if (state_o !== 3'd1 || busy !== 1'b1) begin
         errors++; $display("FAIL rearm: state=%0d busy=%0d expected 1/1", state_o, busy);
      end
      do_abort();
   endtask

   task automatic test_clamp_reset();
      int base;
      do_abort();
      base = wr_cnt;
      do_arm(10'd1020, 10'd10, 30'd0, 30'd0);
      run_count(1100, 1'b0);
      tick();
      checks++;
      if (wr_cnt - base !== 1024 || last_addr !== 10'd1023) begin
         errors++; $display("FAIL clamp_writes: writes=%0d last=%0d expected 1024/1023", wr_cnt - base, last_addr);
      end
      checks++;
      if (trig_addr !== 10'd1020 || start_addr !== 10'd0) begin
         errors++; $display("FAIL clamp_trig: trig=%0d start=%0d expected 1020/0", trig_addr, start_addr);
      end
      do_abort();
      do_arm(10'd2, 10'd0, 30'd1, 30'd1);
      probe = 30'd0;
      tick(); tick(); tick();
      checks++;
      if (state_o !== 3'd2 || wr_en !== 1'b1) begin
         errors++; $display("FAIL rst_pre: state=%0d wr_en=%0d expected 2/1", state_o, wr_en);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({wr_en, wr_addr, wr_data, trig_addr, start_addr, busy, done, state_o} !== 66'd0 ||
          {s_wr_en, s_busy, s_done, s_state_o} !== 6'd0) begin
         errors++; $display("FAIL async_reset: state=%0d wr_en=%0d addr=%0d busy=%0d expected all 0",
                            state_o, wr_en, wr_addr, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      do_arm(10'd0, 10'd0, 30'd0, 30'd0);
      checks++;
      if (state_o !== 3'd2) begin errors++; $display("FAIL post_rst_arm: state=%0d expected 2", state_o); end
      tick();
      checks++;
      if (done !== 1'b1 || wr_addr !== 10'd0 || trig_addr !== 10'd0) begin
         errors++; $display("FAIL post_rst_cap: done=%0d addr=%0d trig=%0d expected 1/0/0", done, wr_addr, trig_addr);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_pre_post_zero();
      test_wrap();
      test_match_in_fill();
      test_abort();
      test_clamp_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
